csr_commit_unit: RTL and testbench

CSR_COMMIT_UNIT -- requirements
Module: csr_commit_unit

---
 rtl/drac_pkg.sv | 29 ++
 rtl/commit_retire_mask.sv | 38 +++
 rtl/csr_commit_unit.sv | 165 ++++++++++++++++
 tb/tb_csr_commit_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drac_pkg.sv
// ----------------------------------------------------------------------------
// drac_pkg
// Shared types for the commit stage and the CSR file interface.
//   csr_cmd_t          : operation requested from the CSR file
//   csr_addr_t         : 12-bit CSR address
//   csr_commit_state_t : states of the CSR commit sequencer
//   CSR_TIMEOUT_DEFAULT: cycles the sequencer waits for a CSR response
// ----------------------------------------------------------------------------
package drac_pkg;

    typedef enum logic [2:0] {
        CSR_CMD_NOPE  = 3'd0,
        CSR_CMD_WRITE = 3'd1,
        CSR_CMD_SET   = 3'd2,
        CSR_CMD_CLEAR = 3'd3,
        CSR_CMD_READ  = 3'd4
    } csr_cmd_t;

    typedef logic [11:0] csr_addr_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } csr_commit_state_t;

    localparam int CSR_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/commit_retire_mask.sv
// ----------------------------------------------------------------------------
// commit_retire_mask
// In-order retire mask for the commit slots when no CSR access is in flight.
//   commit_valid  : slot k holds a committable instruction
//   commit_ex     : slot k carries an exception
//   commit_serial : slot k is serialising
//   mem_stall     : slot 0 stalled in the memory stage
//   xcpt          : slot-0 exception is being taken
//   retire_mask   : slot k retires this cycle
// ----------------------------------------------------------------------------
module commit_retire_mask #(
    parameter int COMMIT_WIDTH = 2
) (
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic [COMMIT_WIDTH-1:0] commit_ex,
    input  logic [COMMIT_WIDTH-1:0] commit_serial,
    input  logic                    mem_stall,
    input  logic                    xcpt,
    output logic [COMMIT_WIDTH-1:0] retire_mask
);

    // Walk the slots oldest-first; once one slot fails to retire, or is an
    // exception/serialising instruction, nothing younger may retire with it.
    // A taken exception retires slot 0 even while the memory stage stalls.
    always_comb begin : mask_chain
        logic chain;
        retire_mask    = '0;
        chain          = commit_valid[0] && (!mem_stall || xcpt);
        retire_mask[0] = chain;
        for (int k = 1; k < COMMIT_WIDTH; k++) begin
            chain = chain && !commit_ex[k-1] && !commit_serial[k-1]
                          && commit_valid[k] && !commit_ex[k] && !commit_serial[k]
                          && !xcpt;
            retire_mask[k] = chain;
        end
    end

endmodule

// File: rtl/csr_commit_unit.sv
// ----------------------------------------------------------------------------
// csr_commit_unit
// Commit-stage retire control with a sequencer for slot-0 CSR accesses.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_i                 : abort any CSR operation, retire nothing
//   commit_*_i              : per-slot valid / exception / serial / CSR flags
//   slot0_cmd/addr/data_i   : CSR request fields of slot 0
//   fp_status_i             : per-slot NV,DZ,OF,UF,NX flags
//   commit_xcpt_i           : slot-0 exception taken
//   mem_commit_stall_i      : slot 0 stalled in the memory stage
//   csr_req_*               : valid/ready request channel to the CSR file
//   csr_resp_valid_i        : CSR file completed the accepted request
//   retire_o, fp_status_o   : retire mask and OR of retired FP flags
//   busy_o, timeout_o       : CSR access in flight; response timed out
// ----------------------------------------------------------------------------
module csr_commit_unit
    import drac_pkg::*;
#(
    parameter int COMMIT_WIDTH = 2,
    parameter int CSR_TIMEOUT  = CSR_TIMEOUT_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [COMMIT_WIDTH-1:0]     commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]     commit_ex_i,
    input  logic [COMMIT_WIDTH-1:0]     commit_serial_i,
    input  logic [COMMIT_WIDTH-1:0]     commit_csr_i,
    input  csr_cmd_t                    slot0_cmd_i,
    input  csr_addr_t                   slot0_addr_i,
    input  logic [63:0]                 slot0_data_i,
    input  logic [COMMIT_WIDTH-1:0][4:0] fp_status_i,
    input  logic                        commit_xcpt_i,
    input  logic                        mem_commit_stall_i,
    output logic                        csr_req_valid_o,
    input  logic                        csr_req_ready_i,
    output csr_cmd_t                    csr_req_cmd_o,
    output csr_addr_t                   csr_req_addr_o,
    output logic [63:0]                 csr_req_data_o,
    input  logic                        csr_resp_valid_i,
    output logic [COMMIT_WIDTH-1:0]     retire_o,
    output logic [4:0]                  fp_status_o,
    output logic                        busy_o,
    output logic                        timeout_o
);

    localparam int TIMER_W = $clog2(CSR_TIMEOUT + 1);

    csr_commit_state_t state, state_next;
    logic [TIMER_W-1:0] timer;
    csr_cmd_t           cmd_q;
    csr_addr_t          addr_q;
    logic [63:0]        data_q;
    logic               csr_start;
    logic [COMMIT_WIDTH-1:0] idle_mask;

    // Only slot 0 uses its CSR flag; younger CSR instructions are held back
    // through their serialising flag.
    logic unused_csr_bits;
    assign unused_csr_bits = ^commit_csr_i;

    assign csr_start = commit_valid_i[0] && commit_csr_i[0] && !commit_ex_i[0]
                       && !commit_xcpt_i && !flush_i;

    commit_retire_mask #(
        .COMMIT_WIDTH (COMMIT_WIDTH)
    ) u_retire_mask (
        .commit_valid  (commit_valid_i),
        .commit_ex     (commit_ex_i),
        .commit_serial (commit_serial_i),
        .mem_stall     (mem_commit_stall_i),
        .xcpt          (commit_xcpt_i),
        .retire_mask   (idle_mask)
    );

    // State, WAIT_RESP cycle counter and the captured request. The counter
    // is zero on the first WAIT_RESP cycle and clears whenever we leave.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            timer  <= '0;
            cmd_q  <= CSR_CMD_NOPE;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= state_next;
            if (state == WAIT_RESP && state_next == WAIT_RESP) begin
                timer <= timer + TIMER_W'(1);
            end else begin
                timer <= '0;
            end
            if (state == IDLE && csr_start) begin
                cmd_q  <= slot0_cmd_i;
                addr_q <= slot0_addr_i;
                data_q <= slot0_data_i;
            end
        end
    end

    // Next state and outputs. Flush and reset override everything decided
    // by the state: the request is withdrawn and nothing retires.
    always_comb begin
        state_next      = state;
        retire_o        = '0;
        busy_o          = 1'b0;
        timeout_o       = 1'b0;
        csr_req_valid_o = 1'b0;
        csr_req_cmd_o   = CSR_CMD_NOPE;
        csr_req_addr_o  = '0;
        csr_req_data_o  = '0;
        case (state)
            IDLE: begin
                if (csr_start) begin
                    state_next = REQ;
                end else begin
                    retire_o = idle_mask;
                end
            end
            REQ: begin
                busy_o          = 1'b1;
                csr_req_valid_o = 1'b1;
                csr_req_cmd_o   = cmd_q;
                csr_req_addr_o  = addr_q;
                csr_req_data_o  = data_q;
                if (csr_req_ready_i) begin
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                busy_o = 1'b1;
                if (csr_resp_valid_i) begin
                    retire_o   = COMMIT_WIDTH'(1);
                    state_next = IDLE;
                end else if (timer == TIMER_W'(CSR_TIMEOUT)) begin
                    timeout_o  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (flush_i || rst_i) begin
            state_next      = IDLE;
            retire_o        = '0;
            timeout_o       = 1'b0;
            csr_req_valid_o = 1'b0;
            csr_req_cmd_o   = CSR_CMD_NOPE;
            csr_req_addr_o  = '0;
            csr_req_data_o  = '0;
        end
        if (rst_i) begin
            busy_o = 1'b0;
        end
    end

    // Floating-point flags accumulate only from slots that actually retire.
    always_comb begin
        fp_status_o = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (retire_o[k]) begin
                fp_status_o = fp_status_o | fp_status_i[k];
            end
        end
    end

endmodule

// File: tb/tb_csr_commit_unit.sv
// ----------------------------------------------------------------------------
// tb_csr_commit_unit
// Self-checking bench for csr_commit_unit (4 slots, short CSR timeout).
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model.
// ----------------------------------------------------------------------------
module tb_csr_commit_unit;
    import drac_pkg::*;

    localparam int W   = 4;
    localparam int TMO = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic [W-1:0]       commit_valid, commit_ex, commit_serial, commit_csr;
    csr_cmd_t           slot0_cmd;
    csr_addr_t          slot0_addr;
    logic [63:0]        slot0_data;
    logic [W-1:0][4:0]  fp_status;
    logic               xcpt, mem_stall, req_ready, resp_valid;
    logic               csr_req_valid;
    csr_cmd_t           csr_req_cmd;
    csr_addr_t          csr_req_addr;
    logic [63:0]        csr_req_data;
    logic [W-1:0]       retire;
    logic [4:0]         fp_out;
    logic               busy, timeout;

    always #5 clk = ~clk;

    csr_commit_unit #(
        .COMMIT_WIDTH (W),
        .CSR_TIMEOUT  (TMO)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .flush_i            (flush),
        .commit_valid_i     (commit_valid),
        .commit_ex_i        (commit_ex),
        .commit_serial_i    (commit_serial),
        .commit_csr_i       (commit_csr),
        .slot0_cmd_i        (slot0_cmd),
        .slot0_addr_i       (slot0_addr),
        .slot0_data_i       (slot0_data),
        .fp_status_i        (fp_status),
        .commit_xcpt_i      (xcpt),
        .mem_commit_stall_i (mem_stall),
        .csr_req_valid_o    (csr_req_valid),
        .csr_req_ready_i    (req_ready),
        .csr_req_cmd_o      (csr_req_cmd),
        .csr_req_addr_o     (csr_req_addr),
        .csr_req_data_o     (csr_req_data),
        .csr_resp_valid_i   (resp_valid),
        .retire_o           (retire),
        .fp_status_o        (fp_out),
        .busy_o             (busy),
        .timeout_o          (timeout)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one outstanding CSR transaction, described by whether
    // it exists, whether the CSR file has accepted it, and how long we waited.
    bit          m_pending  = 1'b0;
    bit          m_accepted = 1'b0;
    int          m_waited   = 0;
    csr_cmd_t    m_cmd      = CSR_CMD_NOPE;
    csr_addr_t   m_addr     = '0;
    logic [63:0] m_data     = '0;

    logic [W-1:0] e_retire;
    logic [4:0]   e_fp;
    logic         e_busy, e_tmo, e_rv, e_start;
    csr_cmd_t     e_cmd;
    csr_addr_t    e_addr;
    logic [63:0]  e_data;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Oldest-first retire prefix when no CSR access is outstanding.
    function automatic logic [W-1:0] idleRetire();
        logic [W-1:0] m = '0;
        if (!commit_valid[0]) return m;
        if (mem_stall && !xcpt) return m;
        m[0] = 1'b1;
        if (xcpt) return m;
        for (int k = 1; k < W; k++) begin
            if (commit_ex[k-1] || commit_serial[k-1]) break;
            if (!commit_valid[k] || commit_ex[k] || commit_serial[k]) break;
            m[k] = 1'b1;
        end
        return m;
    endfunction

    function automatic void computeExpected();
        e_start  = !rst && !flush && !m_pending && commit_valid[0] && commit_csr[0]
                   && !commit_ex[0] && !xcpt;
        e_retire = '0;
        e_tmo    = 1'b0;
        if (!rst && !flush) begin
            if (!m_pending) begin
                if (!e_start) e_retire = idleRetire();
            end else if (m_accepted) begin
                if (resp_valid) e_retire = W'(1);
                else if (m_waited == TMO) e_tmo = 1'b1;
            end
        end
        e_busy = !rst && m_pending;
        e_rv   = !rst && !flush && m_pending && !m_accepted;
        e_cmd  = e_rv ? m_cmd  : CSR_CMD_NOPE;
        e_addr = e_rv ? m_addr : '0;
        e_data = e_rv ? m_data : '0;
        e_fp   = '0;
        for (int k = 0; k < W; k++) if (e_retire[k]) e_fp |= fp_status[k];
    endfunction

    function automatic void updateModel();
        if (rst || flush) begin
            m_pending  = 1'b0;
            m_accepted = 1'b0;
        end else if (!m_pending) begin
            if (e_start) begin
                m_pending  = 1'b1;
                m_accepted = 1'b0;
                m_cmd      = slot0_cmd;
                m_addr     = slot0_addr;
                m_data     = slot0_data;
            end
        end else if (!m_accepted) begin
            if (req_ready) begin
                m_accepted = 1'b1;
                m_waited   = 0;
            end
        end else if (resp_valid || e_tmo) begin
            m_pending  = 1'b0;
            m_accepted = 1'b0;
        end else begin
            m_waited++;
        end
    endfunction

    // Inputs are set just after a falling edge; outputs are compared with
    // the model mid-cycle, then the model advances with the rising edge.
    task automatic runCycle();
        #1;
        computeExpected();
        checkOutput("retire",   64'(retire),        64'(e_retire));
        checkOutput("fp_out",   64'(fp_out),        64'(e_fp));
        checkOutput("busy",     64'(busy),          64'(e_busy));
        checkOutput("timeout",  64'(timeout),       64'(e_tmo));
        checkOutput("reqvalid", 64'(csr_req_valid), 64'(e_rv));
        checkOutput("reqcmd",   64'(csr_req_cmd),   64'(e_cmd));
        checkOutput("reqaddr",  64'(csr_req_addr),  64'(e_addr));
        checkOutput("reqdata",  csr_req_data,       e_data);
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic clearInputs();
        rst = 1'b0; flush = 1'b0;
        commit_valid = '0; commit_ex = '0; commit_serial = '0; commit_csr = '0;
        slot0_cmd = CSR_CMD_NOPE; slot0_addr = '0; slot0_data = '0;
        fp_status = '0; xcpt = 1'b0; mem_stall = 1'b0;
        req_ready = 1'b0; resp_valid = 1'b0;
    endtask

    task automatic startCsr(input csr_cmd_t cmd, input csr_addr_t addr, input logic [63:0] data);
        clearInputs();
        commit_valid = 4'b0001; commit_csr = 4'b0001; commit_serial = 4'b0001;
        slot0_cmd = cmd; slot0_addr = addr; slot0_data = data;
    endtask

    task automatic applyStimulus(input int resp_pct);
        rst           = ($urandom_range(0, 63) == 0);
        flush         = ($urandom_range(0, 15) == 0);
        commit_valid  = W'($urandom);
        commit_ex     = W'($urandom) & W'($urandom) & W'($urandom);
        commit_serial = W'($urandom) & W'($urandom);
        commit_csr    = W'($urandom) & W'($urandom);
        slot0_cmd     = csr_cmd_t'($urandom_range(0, 4));
        slot0_addr    = csr_addr_t'($urandom);
        slot0_data    = {$urandom, $urandom};
        fp_status     = (W*5)'({$urandom, $urandom});
        xcpt          = ($urandom_range(0, 15) == 0);
        mem_stall     = ($urandom_range(0, 3) == 0);
        req_ready     = ($urandom_range(0, 1) == 0);
        resp_valid    = ($urandom_range(0, 99) < resp_pct);
    endtask

    initial begin
        int ret_seen;
        int ret_cycle;
        clearInputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset held with live inputs: every output stays at zero.
        commit_valid = 4'b1111; fp_status = 20'hfffff;
        #1;
        checkOutput("rst_retire", 64'(retire), 64'h0);
        checkOutput("rst_cmd", 64'(csr_req_cmd), 64'(CSR_CMD_NOPE));
        runCycle();

        // Two plain ops retire together; a store in slot 1 stops at slot 0.
        clearInputs();
        commit_valid = 4'b0011;
        #1 checkOutput("alu_pair", 64'(retire), 64'h3);
        runCycle();
        commit_serial = 4'b0010;
        #1 checkOutput("store_slot1", 64'(retire), 64'h1);
        runCycle();

        // Exception in slot 2 cuts the mask; FP flags from slots 0 and 1 only.
        clearInputs();
        commit_valid = 4'b1111; commit_ex = 4'b0100;
        fp_status = {5'h08, 5'h04, 5'h02, 5'h01};
        #1;
        checkOutput("ex_slot2", 64'(retire), 64'h3);
        checkOutput("ex_fp", 64'(fp_out), 64'h03);
        runCycle();

        // CSRRW: accepted on first REQ cycle, response two cycles into WAIT.
        startCsr(CSR_CMD_WRITE, 12'h305, 64'h0123_4567_89ab_cdef);
        #1;
        checkOutput("det_retire", 64'(retire), 64'h0);
        checkOutput("det_busy", 64'(busy), 64'h0);
        runCycle();
        clearInputs();
        req_ready = 1'b1; slot0_data = '1; slot0_cmd = CSR_CMD_CLEAR;
        #1;
        checkOutput("req_valid", 64'(csr_req_valid), 64'h1);
        checkOutput("req_cmd", 64'(csr_req_cmd), 64'(CSR_CMD_WRITE));
        checkOutput("req_data", csr_req_data, 64'h0123_4567_89ab_cdef);
        checkOutput("req_busy", 64'(busy), 64'h1);
        runCycle();
        req_ready = 1'b0;
        ret_seen = 0; ret_cycle = 0;
        for (int c = 2; c <= 5; c++) begin
            resp_valid = (c == 4);
            #1;
            checkOutput("csrrw_busy", 64'(busy), (c <= 4) ? 64'h1 : 64'h0);
            if (retire != '0) begin
                ret_seen++;
                ret_cycle = c;
                checkOutput("csrrw_retire", 64'(retire), 64'h1);
            end
            runCycle();
        end
        checkOutput("csrrw_once", 64'(ret_seen), 64'h1);
        checkOutput("csrrw_latency", 64'(ret_cycle), 64'h4);

        // Response never arrives: timeout pulse on the 8th cycle after entry.
        startCsr(CSR_CMD_READ, 12'h001, 64'h0);
        runCycle();
        clearInputs();
        req_ready = 1'b1;
        runCycle();
        req_ready = 1'b0;
        for (int t = 0; t <= 9; t++) begin
            #1;
            checkOutput("tmo_pulse", 64'(timeout), (t == TMO) ? 64'h1 : 64'h0);
            checkOutput("tmo_busy", 64'(busy), (t <= TMO) ? 64'h1 : 64'h0);
            runCycle();
        end

        // Flush together with the response: no retire, back to idle; a late
        // response in idle is ignored.
        startCsr(CSR_CMD_SET, 12'h002, 64'h5);
        runCycle();
        clearInputs();
        req_ready = 1'b1;
        runCycle();
        req_ready = 1'b0;
        runCycle();
        resp_valid = 1'b1; flush = 1'b1;
        #1 checkOutput("flush_resp", 64'(retire), 64'h0);
        runCycle();
        flush = 1'b0;
        #1;
        checkOutput("flush_idle", 64'(busy), 64'h0);
        checkOutput("stray_resp", 64'(retire), 64'h0);
        runCycle();

        // Reset during WAIT_RESP abandons the request.
        startCsr(CSR_CMD_WRITE, 12'h003, 64'h9);
        runCycle();
        clearInputs();
        req_ready = 1'b1;
        runCycle();
        clearInputs();
        rst = 1'b1; resp_valid = 1'b1;
        #1 checkOutput("rst_mid", 64'(retire), 64'h0);
        runCycle();
        clearInputs();
        #1 checkOutput("rst_mid_idle", 64'(busy), 64'h0);
        runCycle();

        // Randomized traffic: frequent responses, then rare ones for timeouts.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(35);
            runCycle();
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(4);
            runCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
